// File: rtl/wvb_rd_arbiter_pkg.sv
// wvb_rd_arbiter_pkg
//   Shared definitions for the waveform-buffer read arbiter: FSM state
//   encoding and default timing parameters.
package wvb_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_HOLDOFF = 2'd2
  } arb_state_e;

  localparam int DEF_HOLDOFF = 2;
  localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/wvb_rd_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority encoder. Returns the first set
//   request at index ptr, ptr+1, ... wrapping N-1 -> 0.
//   Ports:
//     req_i  [N-1:0]  request vector
//     ptr_i  [W-1:0]  highest-priority index this round
//     pick_o [W-1:0]  selected index (0 when none)
//     any_o           at least one request set
module rr_pick #(
  parameter int N = 24,
  parameter int W = 5
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] pick_o,
  output logic         any_o
);

  int idx;

  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!any_o && req_i[idx]) begin
        any_o  = 1'b1;
        pick_o = W'(idx);
      end
    end
  end

endmodule

// File: rtl/wvb_rd_arbiter.sv
// wvb_rd_arbiter
//   Round-robin read arbiter sharing one waveform reader among P_N_CHAN
//   waveform buffers. Grants one enabled, non-empty channel at a time,
//   steers reader strobes one-hot to it and muxes its data back.
//   Optional macro WVB_RD_ARB_TIMEOUT_EN: BUSY timeout forcing rddone
//   after P_TIMEOUT cycles, with sticky timeout_err_o.
//   Ports:
//     clk_i, rst_i (async, active low)
//     chan_en_i, hdr_empty_i            per-channel enable / header-empty
//     hdr_data_i, wvb_data_i            concatenated buffer outputs
//     rd_hdr_rdreq_i, rd_wvb_rdreq_i, rd_done_i   reader strobes
//     hdr_rdreq_o, wvb_rdreq_o, wvb_rddone_o      one-hot strobes to buffers
//     rd_start_o, rd_chan_o, rd_busy_o            grant status
//     hdr_data_o, wvb_data_o            data of rd_chan_o
//     grant_cnt_o                       grants since reset
module wvb_rd_arbiter
  import wvb_rd_arbiter_pkg::*;
#(
  parameter int P_N_CHAN     = 24,
  parameter int P_CHAN_WIDTH = 5,
  parameter int P_DATA_WIDTH = 170,
  parameter int P_HDR_WIDTH  = 128,
  parameter int P_HOLDOFF    = DEF_HOLDOFF,
  parameter int P_TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [P_N_CHAN-1:0]               chan_en_i,
  input  logic [P_N_CHAN-1:0]               hdr_empty_i,
  input  logic [P_HDR_WIDTH*P_N_CHAN-1:0]   hdr_data_i,
  input  logic [P_DATA_WIDTH*P_N_CHAN-1:0]  wvb_data_i,
  input  logic                              rd_hdr_rdreq_i,
  input  logic                              rd_wvb_rdreq_i,
  input  logic                              rd_done_i,
  output logic [P_N_CHAN-1:0]               hdr_rdreq_o,
  output logic [P_N_CHAN-1:0]               wvb_rdreq_o,
  output logic [P_N_CHAN-1:0]               wvb_rddone_o,
  output logic                              rd_start_o,
  output logic [P_CHAN_WIDTH-1:0]           rd_chan_o,
  output logic                              rd_busy_o,
  output logic [P_HDR_WIDTH-1:0]            hdr_data_o,
  output logic [P_DATA_WIDTH-1:0]           wvb_data_o,
  output logic [31:0]                       grant_cnt_o
`ifdef WVB_RD_ARB_TIMEOUT_EN
  ,
  output logic                              timeout_err_o
`endif
);

  arb_state_e              state_q, state_d;
  logic [P_CHAN_WIDTH-1:0] chan_q, chan_d;
  logic [P_CHAN_WIDTH-1:0] ptr_q, ptr_d;
  logic [3:0]              hold_q, hold_d;
  logic [31:0]             gcnt_q, gcnt_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;

  logic [P_N_CHAN-1:0]     req;
  logic [P_CHAN_WIDTH-1:0] pick;
  logic                    any;
  logic                    tmo;
  logic                    done_acc;
  logic [P_N_CHAN-1:0]     sel;

  logic [P_N_CHAN-1:0][P_HDR_WIDTH-1:0]  hdr_arr;
  logic [P_N_CHAN-1:0][P_DATA_WIDTH-1:0] wvb_arr;

  assign req = chan_en_i & ~hdr_empty_i;

  rr_pick #(.N(P_N_CHAN), .W(P_CHAN_WIDTH)) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .any_o  (any)
  );

`ifdef WVB_RD_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q;
  logic        terr_q;

  // tcnt_q equals the BUSY cycle index (0 on the rd_start cycle), so the
  // forced rddone lands exactly P_TIMEOUT cycles after rd_start.
  assign tmo = (state_q == ST_BUSY) && (tcnt_q == 16'(P_TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE)      tcnt_q <= '0;
      else if (state_q == ST_BUSY) tcnt_q <= tcnt_q + 16'd1;
      if (tmo) terr_q <= 1'b1;
    end
  end

  assign timeout_err_o = terr_q;
`else
  assign tmo = 1'b0;
`endif

  assign done_acc = (state_q == ST_BUSY) && (rd_done_i || tmo);

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      gcnt_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gcnt_q  <= gcnt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gcnt_d  = gcnt_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: if (any) begin
        chan_d  = pick;
        start_d = 1'b1;
        busy_d  = 1'b1;
        gcnt_d  = gcnt_q + 32'd1;
        state_d = ST_BUSY;
      end
      ST_BUSY: if (done_acc) begin
        busy_d  = 1'b0;
        ptr_d   = (chan_q == P_CHAN_WIDTH'(P_N_CHAN-1)) ? '0 : chan_q + 1'b1;
        hold_d  = 4'(P_HOLDOFF);
        state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        hold_d = hold_q - 4'd1;
        // <= 1 also recovers a zero count instead of wrapping to 15
        if (hold_q <= 4'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs: strobes depend on state_q, so async reset drops them at once
  always_comb begin
    sel = '0;
    if (state_q == ST_BUSY) sel[chan_q] = 1'b1;
    hdr_rdreq_o  = sel & {P_N_CHAN{rd_hdr_rdreq_i}};
    wvb_rdreq_o  = sel & {P_N_CHAN{rd_wvb_rdreq_i}};
    wvb_rddone_o = sel & {P_N_CHAN{rd_done_i | tmo}};
  end

  assign hdr_arr    = hdr_data_i;
  assign wvb_arr    = wvb_data_i;
  assign hdr_data_o = hdr_arr[chan_q];
  assign wvb_data_o = wvb_arr[chan_q];

  assign rd_start_o  = start_q;
  assign rd_chan_o   = chan_q;
  assign rd_busy_o   = busy_q;
  assign grant_cnt_o = gcnt_q;

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
module tb_wvb_rd_arbiter;
  localparam int N = 24, CW = 5, DW = 170, HW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] chan_en, hdr_empty;
  logic [N-1:0][HW-1:0] hdr_arr;
  logic [N-1:0][DW-1:0] wvb_arr;
  logic rd_hdr_rdreq = 1'b0, rd_wvb_rdreq = 1'b0, rd_done = 1'b0;
  logic [N-1:0] hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic rd_start, rd_busy;
  logic [CW-1:0] rd_chan;
  logic [HW-1:0] hdr_data_out;
  logic [DW-1:0] wvb_data_out;
  logic [31:0] grant_cnt;
`ifdef WVB_RD_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  wvb_rd_arbiter #(.P_N_CHAN(N), .P_CHAN_WIDTH(CW), .P_DATA_WIDTH(DW),
                   .P_HDR_WIDTH(HW), .P_HOLDOFF(2), .P_TIMEOUT(50)) dut (
    .clk_i(clk), .rst_i(rst), .chan_en_i(chan_en), .hdr_empty_i(hdr_empty),
    .hdr_data_i(hdr_arr), .wvb_data_i(wvb_arr),
    .rd_hdr_rdreq_i(rd_hdr_rdreq), .rd_wvb_rdreq_i(rd_wvb_rdreq), .rd_done_i(rd_done),
    .hdr_rdreq_o(hdr_rdreq), .wvb_rdreq_o(wvb_rdreq), .wvb_rddone_o(wvb_rddone),
    .rd_start_o(rd_start), .rd_chan_o(rd_chan), .rd_busy_o(rd_busy),
    .hdr_data_o(hdr_data_out), .wvb_data_o(wvb_data_out), .grant_cnt_o(grant_cnt)
`ifdef WVB_RD_ARB_TIMEOUT_EN
    , .timeout_err_o(timeout_err)
`endif
  );

  // buffer model: each channel holds loaded-consumed waveforms
  int loaded[N];
  int consumed[N];
  int rddone_n[N];

  always_comb begin
    hdr_empty = '1;
    for (int i = 0; i < N; i++) hdr_empty[i] = (loaded[i] == consumed[i]);
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (wvb_rddone[i]) begin
        consumed[i] <= consumed[i] + 1;
        rddone_n[i] <= rddone_n[i] + 1;
      end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (rd_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, rd_start, 1);
  endtask

  // one full read: check grant, strobes, data, then rd_done 10 cycles in
  task automatic serve(input int ch, input string tag);
    logic [N-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    wait_start(tag);
    chk({tag, "_chan"}, rd_chan, ch);
    chk({tag, "_busy"}, rd_busy, 1);
    chk({tag, "_hdr"}, hdr_data_out, hdr_arr[ch]);
    chk({tag, "_wvb"}, wvb_data_out, wvb_arr[ch]);
    rd_hdr_rdreq = 1'b1;
    rd_wvb_rdreq = 1'b1;
    #1;
    chk({tag, "_hdr_rdreq"}, hdr_rdreq, oh);
    chk({tag, "_wvb_rdreq"}, wvb_rdreq, oh);
    rd_hdr_rdreq = 1'b0;
    repeat (10) @(negedge clk);
    rd_done = 1'b1;
    #1;
    chk({tag, "_rddone"}, wvb_rddone, oh);
    @(negedge clk);
    rd_done = 1'b0;
    rd_wvb_rdreq = 1'b0;
    chk({tag, "_released"}, rd_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;
    for (int i = 0; i < N; i++) begin
      hdr_arr[i] = {8{16'(16'hA000 + i)}};
      wvb_arr[i] = {10{17'(i * 3 + 1)}};
      loaded[i] = 0;
    end
    chan_en = '1;
    #1 rst = 1'b0;
    #1;
    // T1: reset state, then idle with empty buffers and reader noise
    chk("rst_busy", rd_busy, 0);
    chk("rst_start", rd_start, 0);
    chk("rst_chan", rd_chan, 0);
    chk("rst_gcnt", grant_cnt, 0);
    chk("rst_strobes", {hdr_rdreq, wvb_rdreq, wvb_rddone}, 0);
    chk("rst_hdr_ch0", hdr_data_out, hdr_arr[0]);
    @(negedge clk);
    rst = 1'b1;
    rd_hdr_rdreq = 1'b1;
    rd_wvb_rdreq = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      rd_done = c[0];
      @(negedge clk);
      if (rd_busy !== 1'b0 || rd_start !== 1'b0 || hdr_rdreq !== '0 ||
          wvb_rdreq !== '0 || wvb_rddone !== '0) bad++;
    end
    rd_done = 1'b0;
    rd_hdr_rdreq = 1'b0;
    rd_wvb_rdreq = 1'b0;
    chk("t1_idle_bad_cycles", bad, 0);
    chk("t1_gcnt", grant_cnt, 0);

    // T2: ch2 and ch5 with two waveforms each -> 2,5,2,5
    loaded[2] = 2;
    loaded[5] = 2;
    @(negedge clk);
    chk("t2_latency", rd_start, 1);
    serve(2, "t2_a");
    serve(5, "t2_b");
    serve(2, "t2_c");
    serve(5, "t2_d");
    chk("t2_gcnt", grant_cnt, 4);
    chk("t2_done2", rddone_n[2], 2);
    chk("t2_done5", rddone_n[5], 2);

    // T3: ch23 then wrap to ch0 ahead of ch22
    loaded[23] = 1;
    wait_start("t3_w");
    loaded[0] = 1;
    loaded[22] = 1;
    serve(23, "t3_a");
    serve(0, "t3_b");
    serve(22, "t3_c");
    chk("t3_gcnt", grant_cnt, 7);

    // T4: masked ch7 skipped; mask cleared mid-read still completes
    chan_en[7] = 1'b0;
    loaded[7] = 1;
    loaded[8] = 1;
    serve(8, "t4_a");
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rd_busy !== 1'b0) bad++;
    end
    chk("t4_masked_idle", bad, 0);
    chan_en[7] = 1'b1;
    wait_start("t4_w");
    chan_en[7] = 1'b0;
    serve(7, "t4_b");
    repeat (5) @(negedge clk);
    chk("t4_done7_once", rddone_n[7], 1);
    chk("t4_gcnt", grant_cnt, 9);
    chan_en[7] = 1'b1;

    // T5: reset mid-read drops strobes asynchronously, restarts from ch0
    loaded[10] = 1;
    wait_start("t5_w");
    chk("t5_chan", rd_chan, 10);
    rd_wvb_rdreq = 1'b1;
    repeat (3) @(negedge clk);
    loaded[3] = 1;
    #1;
    chk("t5_pre_rdreq", wvb_rdreq, 32'h400);
    rst = 1'b0;
    #1;
    chk("t5_rst_rdreq", wvb_rdreq, 0);
    chk("t5_rst_busy", rd_busy, 0);
    chk("t5_rst_gcnt", grant_cnt, 0);
    chk("t5_rst_chan", rd_chan, 0);
    @(negedge clk);
    rst = 1'b1;
    rd_wvb_rdreq = 1'b0;
    serve(3, "t5_a");
    serve(10, "t5_b");
    chk("t5_gcnt", grant_cnt, 2);

`ifdef WVB_RD_ARB_TIMEOUT_EN
    // T6: no rd_done -> forced rddone 50 cycles after rd_start
    loaded[4] = 1;
    wait_start("t6_w");
    chk("t6_err_pre", timeout_err, 0);
    k = 0;
    while (wvb_rddone[4] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_tmo_cycles", k, 50);
    chk("t6_rddone_oh", wvb_rddone, 32'h10);
    @(negedge clk);
    chk("t6_err", timeout_err, 1);
    chk("t6_busy", rd_busy, 0);
    repeat (20) @(negedge clk);
    chk("t6_err_sticky", timeout_err, 1);
    chk("t6_done4", rddone_n[4], 1);
`else
    k = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
